// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-input valid/ready stream mux, fixed-select or round-robin, one registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_nx1 #(
    parameter int N = 5,
    parameter int W = 8,
    parameter int SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic            out_last,
    output logic [SELW-1:0] out_ch,
    input  logic            out_ready
);
    logic [SELW-1:0] ptr_q, rr_ch, gnt_ch, nxt_ptr;
    logic            rr_ok, fix_ok, gnt_ok, load_en, xfer;

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    // Scan from the farthest offset down so the channel nearest the pointer wins.
    always_comb begin
        rr_ok = 1'b0;
        rr_ch = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[wrap(int'(ptr_q) + i)]) begin
                rr_ok = 1'b1;
                rr_ch = SELW'(wrap(int'(ptr_q) + i));
            end
        end
    end

    assign fix_ok  = (int'(sel) < N) && in_valid[sel];
    assign load_en = !out_valid || out_ready;

`ifdef STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;
    state_t          state_q, state_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;

    assign gnt_ok = (state_q == LOCKED) ? 1'b1 : (mode ? rr_ok : fix_ok);
    assign gnt_ch = (state_q == LOCKED) ? lock_ch_q : (mode ? rr_ch : sel);

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            state_d   = in_last[gnt_ch] ? ARB : LOCKED;
            lock_ch_d = gnt_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    assign gnt_ok = mode ? rr_ok : fix_ok;
    assign gnt_ch = mode ? rr_ch : sel;
`endif

    assign in_ready = (gnt_ok && load_en && !rst) ? (N'(1) << gnt_ch) : '0;
    assign xfer     = |(in_valid & in_ready);
    assign nxt_ptr  = (int'(gnt_ch) == N - 1) ? '0 : gnt_ch + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            ptr_q     <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt_ch)*W +: W];
            out_last  <= in_last[gnt_ch];
            out_ch    <= gnt_ch;
            ptr_q     <= nxt_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
